fifo_rd_arbiter: RTL and testbench

Read-domain arbiter for the async FIFO. It shares the single FIFO read port among NREQ consumers in the r_clk domain, using round-robin arbitration with a bounded burst per grant. It drives the read request into the read-pointer/empty logic and returns each popped word to its consumer, tagged with the consumer's ID. It sits between the FIFO's read-pointer/empty block plus its combinational-read memory and the downstream consumers.

---
 rtl/fifo_rd_arbiter.sv | 117 +++++++++++
 tb/tb_fifo_rd_arbiter.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_arbiter.sv
`default_nettype none
// ---- fifo_rd_arbiter: round-robin, burst-limited sharing of the FIFO read port (rev 1.0) ----
// Define FIFO_RD_ARB_PRIO_EN to give requester 0 fixed priority at every IDLE decision.
module fifo_rd_arbiter #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4,
  parameter int BURST = 4
) (
  input  logic                    r_clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req,
  input  logic                    empty,
  input  logic [WIDTH-1:0]        rdata_in,
  output logic                    rd_rq,
  output logic [NREQ-1:0]         gnt,
  output logic [WIDTH-1:0]        dout,
  output logic                    dout_valid,
  output logic [$clog2(NREQ)-1:0] dout_id
);

  localparam int IDW = $clog2(NREQ);
  localparam int CW  = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BURST - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t         state, state_next;
  logic [IDW-1:0] owner, owner_next;
  logic [IDW-1:0] last, last_next;
  logic [IDW-1:0] pick;
  logic [CW-1:0]  count, count_next;
  logic           found;
  logic           pop;
  int             idx;

  // First requester found searching upward from the slot after the previous owner
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = int'(last) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req[idx]) begin
        pick  = IDW'(idx);
        found = 1'b1;
      end
    end
`ifdef FIFO_RD_ARB_PRIO_EN
    if (req[0]) pick = '0;
`else
`endif
  end

  assign gnt   = (state == GRANT) ? (NREQ'(1) << owner) : '0;
  assign rd_rq = (state == GRANT) && req[owner];
  assign pop   = rd_rq && !empty;

  always_comb begin
    state_next = state;
    owner_next = owner;
    last_next  = last;
    count_next = count;
    case (state)
      IDLE: begin
        if (|req) begin
          owner_next = pick;
          state_next = GRANT;
        end
      end
      GRANT: begin
        // Owner leaves on request drop or on the final pop of its burst
        if (!req[owner] || (pop && count == LAST_BEAT)) begin
          state_next = IDLE;
          last_next  = owner;
          count_next = '0;
        end else if (pop) begin
          count_next = count + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge r_clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      owner <= '0;
      last  <= IDW'(NREQ - 1);
      count <= '0;
    end else begin
      state <= state_next;
      owner <= owner_next;
      last  <= last_next;
      count <= count_next;
    end
  end

  always_ff @(posedge r_clk or negedge rst_n) begin
    if (!rst_n) begin
      dout       <= '0;
      dout_id    <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= pop;
      if (pop) begin
        dout    <= rdata_in;
        dout_id <= owner;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_arbiter.sv
`default_nettype none
// ---- tb_fifo_rd_arbiter: randomized bench against a queue-based reference model (rev 1.0) ----
// Honours FIFO_RD_ARB_PRIO_EN in the reference model when the design is built with it.
module tb_fifo_rd_arbiter;

  localparam int WIDTH = 8;
  localparam int NREQ  = 4;
  localparam int BURST = 4;
  localparam int IDW   = $clog2(NREQ);

  logic             r_clk;
  logic             rst_n;
  logic [NREQ-1:0]  req;
  logic             empty;
  logic [WIDTH-1:0] rdata_in;
  logic             rd_rq;
  logic [NREQ-1:0]  gnt;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic [IDW-1:0]   dout_id;

  fifo_rd_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .BURST(BURST)) dut (
    .r_clk(r_clk), .rst_n(rst_n), .req(req), .empty(empty), .rdata_in(rdata_in),
    .rd_rq(rd_rq), .gnt(gnt), .dout(dout), .dout_valid(dout_valid), .dout_id(dout_id)
  );

  initial r_clk = 1'b0;
  always #5 r_clk = ~r_clk;

  int n_cmp = 0;
  int n_err = 0;

  // FIFO contents and reference model: owner < 0 means no grant is held
  logic [WIDTH-1:0] q[$];
  int               m_owner, m_last, m_pops, m_did;
  bit               m_dv;
  logic [WIDTH-1:0] m_dout;
  bit               rec;
  int               ids[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int pick_next();
`ifdef FIFO_RD_ARB_PRIO_EN
    if (req[0]) return 0;
`else
`endif
    for (int k = 1; k <= NREQ; k++)
      if (req[(m_last + k) % NREQ]) return (m_last + k) % NREQ;
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_last = NREQ - 1; m_pops = 0; m_dv = 0; m_dout = '0; m_did = 0;
    q.delete();
  endtask

  // Compare the DUT against the model, then advance the model over the coming edge
  task automatic step_model();
    logic [NREQ-1:0] eg;
    bit erq, p;
    eg  = (m_owner < 0) ? '0 : (NREQ'(1) << m_owner);
    erq = (m_owner >= 0) && req[m_owner];
    check("gnt", 32'(gnt), 32'(eg));
    check("rd_rq", 32'(rd_rq), 32'(erq));
    check("dout_valid", 32'(dout_valid), 32'(m_dv));
    if (m_dv) begin
      check("dout", 32'(dout), 32'(m_dout));
      check("dout_id", 32'(dout_id), 32'(m_did));
    end
    if (rec && dout_valid) ids.push_back(int'(dout_id));
    p    = erq && !empty;
    m_dv = p;
    if (p) begin
      m_dout = q.pop_front();
      m_did  = m_owner;
    end
    if (m_owner < 0) begin
      if (req != '0) m_owner = pick_next();
    end else if (!req[m_owner]) begin
      m_last = m_owner; m_owner = -1; m_pops = 0;
    end else if (p) begin
      m_pops++;
      if (m_pops == BURST) begin
        m_last = m_owner; m_owner = -1; m_pops = 0;
      end
    end
  endtask

  task automatic cycle(input logic [NREQ-1:0] r, input int push_n);
    for (int i = 0; i < push_n; i++) q.push_back(WIDTH'($urandom));
    req      = r;
    empty    = (q.size() == 0);
    rdata_in = empty ? WIDTH'($urandom) : q[0];
    @(negedge r_clk);
    step_model();
    @(posedge r_clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_rd_rq", 32'(rd_rq), 32'h0);
    check("rst_dout_valid", 32'(dout_valid), 32'h0);
    check("rst_dout", 32'(dout), 32'h0);
    check("rst_dout_id", 32'(dout_id), 32'h0);
    model_reset();
    @(posedge r_clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; req = '0; empty = 1'b1; rdata_in = '0; rec = 0;
    model_reset();
    #2;
    do_reset();

    // Single consumer drains three words, then keeps requesting on an empty FIFO
    cycle(4'b0001, 3);
    repeat (7) cycle(4'b0001, 0);
    repeat (2) cycle(4'b0000, 0);

    // All four requesting with 16 words queued
    do_reset();
    rec = 1;
    cycle(4'b1111, 16);
    repeat (24) cycle(4'b1111, 0);
    rec = 0;
    check("burst_words", 32'(ids.size()), 32'd16);
    for (int i = 0; i < ids.size() && i < 16; i++) begin
`ifdef FIFO_RD_ARB_PRIO_EN
      check("burst_id_seq", 32'(ids[i]), 32'd0);
`else
      check("burst_id_seq", 32'(ids[i]), 32'(i / BURST));
`endif
    end
    repeat (2) cycle(4'b0000, 0);

    // Owner 2 granted while empty, words arrive later
    repeat (4) cycle(4'b0100, 0);
    cycle(4'b0100, 3);
    repeat (5) cycle(4'b0100, 0);
    repeat (2) cycle(4'b0000, 0);

    // Requester 1 drops after two pops; the next grant moves on
    cycle(4'b0010, 8);
    repeat (2) cycle(4'b0010, 0);
    repeat (8) cycle(4'b1001, 0);
    repeat (2) cycle(4'b0000, 0);

    // Reset in the middle of a burst, then requester 0 wins first
    repeat (3) cycle(4'b1111, 4);
    do_reset();
    cycle(4'b1111, 4);
    check("first_gnt_after_rst", 32'(gnt), 32'h1);
    repeat (6) cycle(4'b1111, 0);

    // Randomized traffic
    for (int n = 0; n < 500; n++)
      cycle(NREQ'($urandom), (q.size() < 12) ? $urandom_range(0, 2) : 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
